// File: rtl/dmem_responder.sv
// Purpose: data-memory target; one serial byte-enabled load/store per valid/ready request, zeroing its RAM after reset.
// Latency: accept edge T -> rsp_valid from edge T+WAIT_CYCLES+1; req_ready rises DEPTH cycles after reset release.
// Backpressure: req_ready is low outside IDLE; the response and its data are held until rsp_valid & rsp_ready.
module dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI = LO + 33'(4 * DEPTH);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY, S_RESP} state_t;

    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic          req_err_c;
    logic [AW-1:0] req_idx_c;
    logic [31:0]   mem_rd_c;
    logic [31:0]   merge_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_widx_c;
    logic [31:0]   mem_wdat_c;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Request decode: misaligned or outside the data window is an error; index is the word offset.
    always_comb begin
        req_err_c = (req_addr[1:0] != 2'b00) | ({1'b0, req_addr} < LO) | ({1'b0, req_addr} >= HI);
        req_idx_c = AW'((req_addr - BASE_ADDR) >> 2);
    end

    // Store merge: enabled lanes take the captured data, the rest keep the current word.
    always_comb begin
        mem_rd_c = mem[idx_q];
        merge_c  = mem_rd_c;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merge_c[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Next-state and registered-output logic for the CLEAR/IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_c    = 1'b0;
        mem_widx_c  = idx_q;
        mem_wdat_c  = merge_c;
        case (state_q)
            S_CLEAR: begin
                mem_we_c   = 1'b1;
                mem_widx_c = clr_idx_q;
                mem_wdat_c = 32'h0;
                clr_idx_d  = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    clr_idx_d   = '0;
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    idx_d       = req_idx_c;
                    wdata_d     = req_wdata;
                    be_d        = req_be;
                    err_d       = req_err_c;
                    cnt_d       = 4'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                // The access edge always follows the accept edge by WAIT_CYCLES+1, so a
                // zero wait still passes through one BUSY cycle with the counter at 0.
                if (cnt_q == 4'd0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = err_q;
                    if (!err_q) begin
                        if (we_q) mem_we_c = 1'b1;
                        else      rsp_rdata_d = mem_rd_c;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_CLEAR;
                clr_idx_d   = '0;
                req_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction and restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            clr_idx_q   <= '0;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory array write port: clear sweep or committed store.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_c) mem[mem_widx_c] <= mem_wdat_c;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int          WAITC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Release reset and count clock edges until req_ready is seen high.
    task automatic release_reset(input string tag);
        int n;
        n = 0;
        rst = 1'b0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (req_ready) break;
        end
        check({tag, "_clear_cycles"}, 32'(n), 32'(DEPTH));
    endtask

    // One full transaction; hold>0 keeps rsp_ready low that many cycles with req_valid pushed.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int lat;
        logic [31:0] d0;
        logic        e0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0;
        while (lat < 50) begin
            if (rsp_valid) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(WAITC + 1));
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        d0 = rsp_rdata; e0 = rsp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, d0);
            check({tag, "_hold_err"}, 32'(rsp_err), 32'(e0));
            check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_post_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_be = 4'h0; rsp_ready = 1'b0;

        // 1: reset values, clear sweep length, top word reads zero
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        release_reset("t1");
        xact("t1_load_top", 1'b0, BASE + 32'h3C, 32'h0, 4'hF, 32'h0, 1'b0, 0);

        // 2: full-word store then load back
        xact("t2_store", 1'b1, BASE + 32'h8, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0);
        xact("t2_load", 1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 0);

        // 3: partial-lane store
        xact("t3_store", 1'b1, BASE + 32'h8, 32'h11223344, 4'b0101, 32'h0, 1'b0, 0);
        xact("t3_load", 1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'hCA22F044, 1'b0, 0);

        // be=0000 store is legal and changes nothing
        xact("t3_store_be0", 1'b1, BASE + 32'h8, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0);

        // 4: error cases leave memory intact
        xact("t4_misaligned", 1'b0, BASE + 32'h2, 32'h0, 4'hF, 32'h0, 1'b1, 0);
        xact("t4_above", 1'b1, BASE + 32'(4 * DEPTH), 32'h12345678, 4'hF, 32'h0, 1'b1, 0);
        xact("t4_below", 1'b0, BASE - 32'h4, 32'h0, 4'hF, 32'h0, 1'b1, 0);
        xact("t4_intact", 1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'hCA22F044, 1'b0, 0);

        // 5: response held under backpressure, requests ignored meanwhile
        xact("t5_hold_load", 1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'hCA22F044, 1'b0, 5);
        xact("t5_hold_err", 1'b0, BASE + 32'h1, 32'h0, 4'hF, 32'h0, 1'b1, 2);
        xact("t5_base_untouched", 1'b0, BASE, 32'h0, 4'hF, 32'h0, 1'b0, 0);

        // 6: reset during BUSY drops the store and reruns the clear
        req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h10; req_wdata = 32'h5A5A5A5A; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("t6_rst_req_ready", 32'(req_ready), 32'd0);
        end
        release_reset("t6");
        check("t6_no_resp", 32'(rsp_valid), 32'd0);
        xact("t6_load_dropped", 1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 0);
        xact("t6_load_cleared", 1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'h0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
